// File: rtl/seq_detect_param.sv
// seq_detect_param: run-time reprogrammable serial pattern detector.
// Shifts in one bit per qualified clock and compares the newest PAT_W bits
// against a loadable pattern. It drives a same-cycle (Mealy) flag, a
// registered (Moore) flag and a saturating match counter.
// The first bit received lines up with the pattern MSB.
module seq_detect_param #(
  parameter int               PAT_W       = 8,
  parameter logic [PAT_W-1:0] RST_PATTERN = 8'b0101_1101,
  parameter int               OVERLAP     = 1,
  parameter int               CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] pattern,
  input  logic             cnt_clr,
  output logic             flag_mealy,
  output logic             flag_moore,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int               FILL_W   = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  logic [PAT_W-1:0]  pat_reg, pat_next;
  logic [PAT_W-2:0]  hist_reg, hist_next;
  logic [FILL_W-1:0] fill_reg, fill_next;
  logic              moore_reg, moore_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;

  logic [PAT_W-2:0]  hist_shift;
  logic [PAT_W-1:0]  window;
  logic [PAT_W-1:0]  match_vec;
  logic              hit;

  // History after accepting din: oldest bit drops out, din enters at the LSB.
  generate
    if (PAT_W == 2) begin : g_hist_w2
      assign hist_shift = din;
    end else begin : g_hist_wn
      assign hist_shift = {hist_reg[PAT_W-3:0], din};
    end
  endgenerate

  // Candidate window: stored history plus the bit being presented right now.
  assign window = {hist_reg, din};

  generate
    for (genvar gi = 0; gi < PAT_W; gi++) begin : g_cmp
      assign match_vec[gi] = (window[gi] == pat_reg[gi]);
    end
  endgenerate

  // A hit needs a full history, so a partial prefix after reset/load never matches.
  assign hit = din_valid & ~cfg_load & ~rst & (fill_reg == FILL_MAX) & (&match_vec);

  assign flag_mealy = hit;
  assign flag_moore = moore_reg;
  assign match_cnt  = cnt_reg;

  // Next-state: load beats data; idle cycles hold history so gaps do not break a match.
  always_comb begin
    pat_next   = pat_reg;
    hist_next  = hist_reg;
    fill_next  = fill_reg;
    moore_next = hit;
    cnt_next   = cnt_reg;

    if (cfg_load) begin
      pat_next   = pattern;
      hist_next  = '0;
      fill_next  = '0;
      moore_next = 1'b0;
    end else if (din_valid) begin
      hist_next = hist_shift;
      if (hit && (OVERLAP == 0)) begin
        fill_next = '0;
      end else if (fill_reg != FILL_MAX) begin
        fill_next = fill_reg + 1'b1;
      end
    end

    // Clear wins over a coincident hit; the count never wraps.
    if (cnt_clr) begin
      cnt_next = '0;
    end else if (hit && (cnt_reg != CNT_MAX)) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_reg   <= RST_PATTERN;
      hist_reg  <= '0;
      fill_reg  <= '0;
      moore_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      pat_reg   <= pat_next;
      hist_reg  <= hist_next;
      fill_reg  <= fill_next;
      moore_reg <= moore_next;
      cnt_reg   <= cnt_next;
    end
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: four instances share one stimulus stream
// (4-bit overlap, 4-bit non-overlap, 4-bit with 2-bit counter, 8-bit default);
// each scenario selects the instance it checks.
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst, din, din_valid, cfg_load, cnt_clr, load8;
  logic [3:0] pattern4;
  logic [7:0] pattern8;
  logic [3:0] mealy_w, moore_w;
  logic [7:0] cnt0, cnt1, cnt3;
  logic [1:0] cnt2;

  logic [1:0] sel;
  logic       sel_mealy, sel_moore;
  logic [7:0] sel_cnt;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic       obs_mealy, obs_moore;
  logic [7:0] obs_cnt;
  logic       exp_hit_q[$];
  logic [7:0] exp_cnt_q[$];

  always #5 clk = ~clk;

  seq_detect_param #(.PAT_W(4), .RST_PATTERN(4'b1101), .OVERLAP(1), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .cfg_load(cfg_load),
    .pattern(pattern4), .cnt_clr(cnt_clr), .flag_mealy(mealy_w[0]),
    .flag_moore(moore_w[0]), .match_cnt(cnt0));

  seq_detect_param #(.PAT_W(4), .RST_PATTERN(4'b1101), .OVERLAP(0), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .cfg_load(cfg_load),
    .pattern(pattern4), .cnt_clr(cnt_clr), .flag_mealy(mealy_w[1]),
    .flag_moore(moore_w[1]), .match_cnt(cnt1));

  seq_detect_param #(.PAT_W(4), .RST_PATTERN(4'b1101), .OVERLAP(1), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .cfg_load(cfg_load),
    .pattern(pattern4), .cnt_clr(cnt_clr), .flag_mealy(mealy_w[2]),
    .flag_moore(moore_w[2]), .match_cnt(cnt2));

  seq_detect_param dut3 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .cfg_load(load8),
    .pattern(pattern8), .cnt_clr(cnt_clr), .flag_mealy(mealy_w[3]),
    .flag_moore(moore_w[3]), .match_cnt(cnt3));

  always_comb begin
    sel_mealy = mealy_w[sel];
    sel_moore = moore_w[sel];
    case (sel)
      2'd0:    sel_cnt = cnt0;
      2'd1:    sel_cnt = cnt1;
      2'd2:    sel_cnt = {6'd0, cnt2};
      default: sel_cnt = cnt3;
    endcase
  end

  // One clocked transaction: inputs set just after an edge, Mealy sampled mid-cycle,
  // Moore and counter sampled just after the next edge.
  task automatic put_bit(input logic d, input logic v, input logic c);
    din = d; din_valid = v; cnt_clr = c;
    #4;
    obs_mealy = sel_mealy;
    @(posedge clk); #1;
    obs_moore = sel_moore;
    obs_cnt   = sel_cnt;
    din_valid = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; din_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic do_load(input logic [3:0] p);
    cfg_load = 1'b1; pattern4 = p; din_valid = 1'b0;
    @(posedge clk); #1;
    cfg_load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; din = 1'b1; din_valid = 1'b1;
    #4;
    n_cmp++; if (mealy_w !== 4'b0000) begin n_bad++; $display("FAIL reset_mealy: got %b want 0000", mealy_w); end
    @(posedge clk); #1;
    rst = 1'b0; din_valid = 1'b0;
    $display("reset: moore=%b cnt=%0d/%0d/%0d/%0d", moore_w, cnt0, cnt1, cnt2, cnt3);
    n_cmp++; if (moore_w !== 4'b0000) begin n_bad++; $display("FAIL reset_moore: got %b want 0000", moore_w); end
    n_cmp++; if ({cnt0, cnt1, cnt2, cnt3} !== 26'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d/%0d/%0d/%0d want 0", cnt0, cnt1, cnt2, cnt3); end
  endtask

  task automatic test_overlap();
    logic [6:0] b = 7'b1101101;
    logic [6:0] h = 7'b0001001;
    logic [7:0] ec = 8'd0;
    logic eh; logic [7:0] ecq;
    do_reset(); do_load(4'b1101); sel = 2'd0;
    for (int i = 0; i < 7; i++) begin
      if (h[6-i]) ec = ec + 8'd1;
      exp_hit_q.push_back(h[6-i]); exp_cnt_q.push_back(ec);
      put_bit(b[6-i], 1'b1, 1'b0);
      eh = exp_hit_q.pop_front(); ecq = exp_cnt_q.pop_front();
      $display("overlap bit %0d din=%b mealy=%b moore=%b cnt=%0d", i + 1, b[6-i], obs_mealy, obs_moore, obs_cnt);
      n_cmp++; if (obs_mealy !== eh) begin n_bad++; $display("FAIL overlap_mealy bit %0d: got %b want %b", i + 1, obs_mealy, eh); end
      n_cmp++; if (obs_moore !== eh) begin n_bad++; $display("FAIL overlap_moore bit %0d: got %b want %b", i + 1, obs_moore, eh); end
      n_cmp++; if (obs_cnt !== ecq) begin n_bad++; $display("FAIL overlap_cnt bit %0d: got %0d want %0d", i + 1, obs_cnt, ecq); end
    end
  endtask

  task automatic test_no_overlap();
    logic [6:0] b = 7'b1101101;
    logic [6:0] h = 7'b0001000;
    logic [7:0] ec = 8'd0;
    logic eh; logic [7:0] ecq;
    do_reset(); do_load(4'b1101); sel = 2'd1;
    for (int i = 0; i < 7; i++) begin
      if (h[6-i]) ec = ec + 8'd1;
      exp_hit_q.push_back(h[6-i]); exp_cnt_q.push_back(ec);
      put_bit(b[6-i], 1'b1, 1'b0);
      eh = exp_hit_q.pop_front(); ecq = exp_cnt_q.pop_front();
      $display("no_overlap bit %0d din=%b mealy=%b moore=%b cnt=%0d", i + 1, b[6-i], obs_mealy, obs_moore, obs_cnt);
      n_cmp++; if (obs_mealy !== eh) begin n_bad++; $display("FAIL no_overlap_mealy bit %0d: got %b want %b", i + 1, obs_mealy, eh); end
      n_cmp++; if (obs_moore !== eh) begin n_bad++; $display("FAIL no_overlap_moore bit %0d: got %b want %b", i + 1, obs_moore, eh); end
      n_cmp++; if (obs_cnt !== ecq) begin n_bad++; $display("FAIL no_overlap_cnt bit %0d: got %0d want %0d", i + 1, obs_cnt, ecq); end
    end
  endtask

  task automatic test_gaps();
    logic [6:0] b = 7'b1101001;
    logic [6:0] v = 7'b1100011;
    logic [6:0] h = 7'b0000001;
    logic [7:0] ec = 8'd0;
    logic eh; logic [7:0] ecq;
    do_reset(); do_load(4'b1101); sel = 2'd0;
    for (int i = 0; i < 7; i++) begin
      if (h[6-i]) ec = ec + 8'd1;
      exp_hit_q.push_back(h[6-i]); exp_cnt_q.push_back(ec);
      put_bit(b[6-i], v[6-i], 1'b0);
      eh = exp_hit_q.pop_front(); ecq = exp_cnt_q.pop_front();
      $display("gaps step %0d din=%b valid=%b mealy=%b moore=%b cnt=%0d", i + 1, b[6-i], v[6-i], obs_mealy, obs_moore, obs_cnt);
      n_cmp++; if (obs_mealy !== eh) begin n_bad++; $display("FAIL gaps_mealy step %0d: got %b want %b", i + 1, obs_mealy, eh); end
      n_cmp++; if (obs_moore !== eh) begin n_bad++; $display("FAIL gaps_moore step %0d: got %b want %b", i + 1, obs_moore, eh); end
      n_cmp++; if (obs_cnt !== ecq) begin n_bad++; $display("FAIL gaps_cnt step %0d: got %0d want %0d", i + 1, obs_cnt, ecq); end
    end
  endtask

  task automatic test_reset_midstream();
    logic [2:0] pre = 3'b110;
    logic [4:0] b = 5'b11101;
    logic [4:0] h = 5'b00001;
    logic [7:0] ec = 8'd0;
    logic eh; logic [7:0] ecq;
    do_reset(); do_load(4'b1101); sel = 2'd0;
    for (int i = 0; i < 3; i++) begin
      put_bit(pre[2-i], 1'b1, 1'b0);
      $display("midrst pre %0d din=%b mealy=%b", i + 1, pre[2-i], obs_mealy);
      n_cmp++; if (obs_mealy !== 1'b0) begin n_bad++; $display("FAIL midrst_pre_mealy %0d: got %b want 0", i + 1, obs_mealy); end
    end
    // History now 110 with full fill: din=1 would complete 1101 without the reset.
    rst = 1'b1; din = 1'b1; din_valid = 1'b1;
    #4;
    $display("midrst reset cycle mealy=%b", mealy_w[0]);
    n_cmp++; if (mealy_w[0] !== 1'b0) begin n_bad++; $display("FAIL midrst_forced_low: got %b want 0", mealy_w[0]); end
    @(posedge clk); #1;
    rst = 1'b0; din_valid = 1'b0;
    n_cmp++; if (moore_w[0] !== 1'b0) begin n_bad++; $display("FAIL midrst_moore: got %b want 0", moore_w[0]); end
    for (int i = 0; i < 5; i++) begin
      if (h[4-i]) ec = ec + 8'd1;
      exp_hit_q.push_back(h[4-i]); exp_cnt_q.push_back(ec);
      put_bit(b[4-i], 1'b1, 1'b0);
      eh = exp_hit_q.pop_front(); ecq = exp_cnt_q.pop_front();
      $display("midrst bit %0d din=%b mealy=%b moore=%b cnt=%0d", i + 1, b[4-i], obs_mealy, obs_moore, obs_cnt);
      n_cmp++; if (obs_mealy !== eh) begin n_bad++; $display("FAIL midrst_mealy bit %0d: got %b want %b", i + 1, obs_mealy, eh); end
      n_cmp++; if (obs_moore !== eh) begin n_bad++; $display("FAIL midrst_moore bit %0d: got %b want %b", i + 1, obs_moore, eh); end
      n_cmp++; if (obs_cnt !== ecq) begin n_bad++; $display("FAIL midrst_cnt bit %0d: got %0d want %0d", i + 1, obs_cnt, ecq); end
    end
  endtask

  task automatic test_saturate();
    logic [7:0] ec = 8'd0;
    logic eh; logic [7:0] ecq;
    do_reset(); do_load(4'b0000); sel = 2'd2;
    for (int i = 0; i < 10; i++) begin
      // Bits 1..8 plain; bit 9 carries cnt_clr with a hit; bit 10 counts again.
      logic hexp = (i >= 3);
      logic clr  = (i == 8);
      if (clr) ec = 8'd0;
      else if (hexp && ec != 8'd3) ec = ec + 8'd1;
      exp_hit_q.push_back(hexp); exp_cnt_q.push_back(ec);
      put_bit(1'b0, 1'b1, clr);
      eh = exp_hit_q.pop_front(); ecq = exp_cnt_q.pop_front();
      $display("saturate bit %0d clr=%b mealy=%b moore=%b cnt=%0d", i + 1, clr, obs_mealy, obs_moore, obs_cnt);
      n_cmp++; if (obs_mealy !== eh) begin n_bad++; $display("FAIL sat_mealy bit %0d: got %b want %b", i + 1, obs_mealy, eh); end
      n_cmp++; if (obs_moore !== eh) begin n_bad++; $display("FAIL sat_moore bit %0d: got %b want %b", i + 1, obs_moore, eh); end
      n_cmp++; if (obs_cnt !== ecq) begin n_bad++; $display("FAIL sat_cnt bit %0d: got %0d want %0d", i + 1, obs_cnt, ecq); end
    end
  endtask

  task automatic test_load_ignores_din();
    logic [7:0] ec = 8'd1;
    logic eh; logic [7:0] ecq;
    sel = 2'd2;
    // History is all zeros and full: din=0 would hit if the load did not take priority.
    cfg_load = 1'b1; pattern4 = 4'b0000; din = 1'b0; din_valid = 1'b1;
    #4;
    $display("load cycle mealy=%b", mealy_w[2]);
    n_cmp++; if (mealy_w[2] !== 1'b0) begin n_bad++; $display("FAIL load_mealy: got %b want 0", mealy_w[2]); end
    @(posedge clk); #1;
    cfg_load = 1'b0; din_valid = 1'b0;
    n_cmp++; if (moore_w[2] !== 1'b0) begin n_bad++; $display("FAIL load_moore: got %b want 0", moore_w[2]); end
    n_cmp++; if (cnt2 !== 2'd1) begin n_bad++; $display("FAIL load_cnt_kept: got %0d want 1", cnt2); end
    for (int i = 0; i < 4; i++) begin
      logic hexp = (i == 3);
      if (hexp) ec = ec + 8'd1;
      exp_hit_q.push_back(hexp); exp_cnt_q.push_back(ec);
      put_bit(1'b0, 1'b1, 1'b0);
      eh = exp_hit_q.pop_front(); ecq = exp_cnt_q.pop_front();
      $display("after_load bit %0d mealy=%b moore=%b cnt=%0d", i + 1, obs_mealy, obs_moore, obs_cnt);
      n_cmp++; if (obs_mealy !== eh) begin n_bad++; $display("FAIL after_load_mealy bit %0d: got %b want %b", i + 1, obs_mealy, eh); end
      n_cmp++; if (obs_cnt !== ecq) begin n_bad++; $display("FAIL after_load_cnt bit %0d: got %0d want %0d", i + 1, obs_cnt, ecq); end
    end
  endtask

  task automatic test_default_pattern();
    logic [23:0] b = 24'b0101_0101_0101_1101_0101_0101;
    logic [23:0] h = 24'h000100;
    logic [7:0] ec = 8'd0;
    logic eh; logic [7:0] ecq;
    do_reset(); sel = 2'd3;
    for (int i = 0; i < 24; i++) begin
      if (h[23-i]) ec = ec + 8'd1;
      exp_hit_q.push_back(h[23-i]); exp_cnt_q.push_back(ec);
      put_bit(b[23-i], 1'b1, 1'b0);
      eh = exp_hit_q.pop_front(); ecq = exp_cnt_q.pop_front();
      $display("default bit %0d din=%b mealy=%b moore=%b cnt=%0d", i + 1, b[23-i], obs_mealy, obs_moore, obs_cnt);
      n_cmp++; if (obs_mealy !== eh) begin n_bad++; $display("FAIL default_mealy bit %0d: got %b want %b", i + 1, obs_mealy, eh); end
      n_cmp++; if (obs_moore !== eh) begin n_bad++; $display("FAIL default_moore bit %0d: got %b want %b", i + 1, obs_moore, eh); end
      n_cmp++; if (obs_cnt !== ecq) begin n_bad++; $display("FAIL default_cnt bit %0d: got %0d want %0d", i + 1, obs_cnt, ecq); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; din = 1'b0; din_valid = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
    load8 = 1'b0; pattern4 = 4'd0; pattern8 = 8'd0; sel = 2'd0;
    @(posedge clk); #1;
    test_reset();
    test_overlap();
    test_no_overlap();
    test_gaps();
    test_reset_midstream();
    test_saturate();
    test_load_ignores_din();
    test_default_pattern();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
